// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// Covers the IDLE/REQUEST state type, the vector stride and the default vector base.
package irq_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        REQUEST = 1'b1
    } irq_state_t;

    localparam int          VECTOR_STRIDE_SHIFT = 4;
    localparam logic [15:0] DEFAULT_VECTOR_BASE = 16'h0100;

    // Each source owns a 16-byte slot above the base address.
    function automatic logic [15:0] vector_addr(input logic [15:0] base, input logic [7:0] idx);
        return base + (16'(idx) << VECTOR_STRIDE_SHIFT);
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-first priority encoder over a request vector.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_IRQ-1:0] request,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    always_comb begin
        valid = |request;
        index = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (request[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending/enable registers, single-request FSM.
// Define IRQ_SYNC_EN to place a two-flop synchronizer ahead of edge detection.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [15:0] VECTOR_BASE = DEFAULT_VECTOR_BASE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic               mask_write,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               reset_irq,
    output logic               irq,
    output logic [15:0]        irq_vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] enable
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    irq_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   active_idx_reg, active_idx_next;
    logic [15:0]        vector_reg, vector_next;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] enable_reg, enable_next;
    logic [NUM_IRQ-1:0] line_prev_reg;
    logic [NUM_IRQ-1:0] lines_in;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] clear_mask;
    logic [NUM_IRQ-1:0] armed;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_index;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_reg, sync2_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_lines;
            sync2_reg <= sync1_reg;
        end
    end

    assign lines_in = sync2_reg;
`else
    assign lines_in = irq_lines;
`endif

    assign edge_det = lines_in & ~line_prev_reg;
    assign armed    = pending_reg & enable_reg;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_priority_encoder (
        .request (armed),
        .valid   (enc_valid),
        .index   (enc_index)
    );

    always_comb begin
        state_next      = state_reg;
        active_idx_next = active_idx_reg;
        vector_next     = vector_reg;
        clear_mask      = '0;
        case (state_reg)
            IDLE: begin
                if (enc_valid) begin
                    state_next      = REQUEST;
                    active_idx_next = enc_index;
                    vector_next     = vector_addr(VECTOR_BASE, 8'(enc_index));
                end
            end
            REQUEST: begin
                // Enable changes are deliberately ignored here; only the ack ends a request.
                if (reset_irq) begin
                    clear_mask = NUM_IRQ'(1) << active_idx_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A fresh edge on the serviced source overrides its clear.
        pending_next = (pending_reg & ~clear_mask) | edge_det;
        enable_next  = mask_write ? mask_data : enable_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            active_idx_reg <= '0;
            vector_reg     <= VECTOR_BASE;
            pending_reg    <= '0;
            enable_reg     <= '0;
            line_prev_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            active_idx_reg <= active_idx_next;
            vector_reg     <= vector_next;
            pending_reg    <= pending_next;
            enable_reg     <= enable_next;
            line_prev_reg  <= lines_in;
        end
    end

    assign irq        = (state_reg == REQUEST);
    assign irq_vector = vector_reg;
    assign pending    = pending_reg;
    assign enable     = enable_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a per-cycle reference model and literal spot checks.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic [3:0]  irq_lines  = '0;
    logic        mask_write = 1'b0;
    logic [3:0]  mask_data  = '0;
    logic        reset_irq  = 1'b0;
    logic        irq;
    logic [15:0] irq_vector;
    logic [3:0]  pending;
    logic [3:0]  enable;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0]  m_pending = '0;
    logic [3:0]  m_enable  = '0;
    logic        m_busy    = 1'b0;
    int          m_idx     = 0;
    logic [15:0] m_vector  = 16'h0100;
    logic [3:0]  m_prev    = '0;
    logic [3:0]  m_dly0    = '0;
    logic [3:0]  m_dly1    = '0;

    irq_controller #(
        .NUM_IRQ     (4),
        .VECTOR_BASE (16'h0100)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_lines  (irq_lines),
        .mask_write (mask_write),
        .mask_data  (mask_data),
        .reset_irq  (reset_irq),
        .irq        (irq),
        .irq_vector (irq_vector),
        .pending    (pending),
        .enable     (enable)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: service the lowest armed source, one request at a time, vector = base + 16*index.
    initial forever begin
        logic [3:0] seen, rises, armed_m, lowbit;
        @(posedge clock or posedge reset);
        if (reset) begin
            m_pending = '0; m_enable = '0; m_busy = 1'b0; m_idx = 0;
            m_vector = 16'h0100; m_prev = '0; m_dly0 = '0; m_dly1 = '0;
        end else begin
`ifdef IRQ_SYNC_EN
            seen   = m_dly1;
            m_dly1 = m_dly0;
            m_dly0 = irq_lines;
`else
            seen = irq_lines;
`endif
            rises  = seen & ~m_prev;
            m_prev = seen;
            if (m_busy) begin
                if (reset_irq) begin
                    m_pending = m_pending & ~(4'b0001 << m_idx);
                    m_busy    = 1'b0;
                end
            end else if ((m_pending & m_enable) != 4'b0000) begin
                armed_m  = m_pending & m_enable;
                lowbit   = armed_m & (~armed_m + 4'd1);
                m_idx    = $clog2(lowbit);
                m_vector = 16'h0100 + 16'(16 * m_idx);
                m_busy   = 1'b1;
            end
            m_pending = m_pending | rises;
            if (mask_write) m_enable = mask_data;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clock);
        check("model_irq",     {15'd0, irq},     {15'd0, m_busy});
        check("model_vector",  irq_vector,       m_vector);
        check("model_pending", {12'd0, pending}, {12'd0, m_pending});
        check("model_enable",  {12'd0, enable},  {12'd0, m_enable});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_mask(input logic [3:0] v);
        mask_write = 1'b1;
        mask_data  = v;
        tick();
        mask_write = 1'b0;
    endtask

    task automatic ack();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
    endtask

    // Rising edge on the given lines for one cycle, then wait until one edge before irq is due.
    task automatic pulse(input logic [3:0] v);
        irq_lines = v;
        tick();
        irq_lines = '0;
        repeat (LAT - 2) tick();
    endtask

    initial begin
        repeat (2) tick();
        check("rst_irq",     {15'd0, irq},     16'h0000);
        check("rst_vector",  irq_vector,       16'h0100);
        check("rst_pending", {12'd0, pending}, 16'h0000);
        check("rst_enable",  {12'd0, enable},  16'h0000);
        reset = 1'b0;
        tick();

        // Single source, latency and ack; enable cleared mid-request keeps irq
        set_mask(4'b0001);
        pulse(4'b0001);
        check("t1_irq_early", {15'd0, irq}, 16'h0000);
        tick();
        check("t1_irq_high", {15'd0, irq}, 16'h0001);
        check("t1_vector",   irq_vector,   16'h0100);
        set_mask(4'b0000);
        check("t1_irq_hold", {15'd0, irq}, 16'h0001);
        set_mask(4'b0001);
        ack();
        check("t1_irq_low",  {15'd0, irq},     16'h0000);
        check("t1_pending",  {12'd0, pending}, 16'h0000);

        // Two simultaneous sources: lowest first, then the other after a low cycle
        set_mask(4'b1111);
        pulse(4'b1010);
        tick();
        check("t2_irq_a",    {15'd0, irq}, 16'h0001);
        check("t2_vector_a", irq_vector,   16'h0110);
        ack();
        check("t2_irq_gap",  {15'd0, irq},     16'h0000);
        check("t2_pending",  {12'd0, pending}, 16'h0008);
        tick();
        check("t2_irq_b",    {15'd0, irq}, 16'h0001);
        check("t2_vector_b", irq_vector,   16'h0130);
        ack();
        check("t2_pending_end", {12'd0, pending}, 16'h0000);

        // Masked source stays pending; ack while idle is ignored; enabling releases it
        set_mask(4'b0000);
        pulse(4'b0100);
        tick();
        check("t3_pending", {12'd0, pending}, 16'h0004);
        check("t3_irq_off", {15'd0, irq},     16'h0000);
        ack();
        check("t3_idle_ack", {12'd0, pending}, 16'h0004);
        set_mask(4'b0100);
        check("t3_enable",   {12'd0, enable}, 16'h0004);
        check("t3_irq_wait", {15'd0, irq},    16'h0000);
        tick();
        check("t3_irq_high", {15'd0, irq}, 16'h0001);
        check("t3_vector",   irq_vector,   16'h0120);
        ack();
        check("t3_pending_end", {12'd0, pending}, 16'h0000);

        // New edge on the active source coincides with its ack: set wins
        set_mask(4'b0001);
        pulse(4'b0001);
        tick();
        check("t4_irq_high", {15'd0, irq}, 16'h0001);
        irq_lines = 4'b0001;
        repeat (LAT - 2) tick();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
        irq_lines = '0;
        check("t4_irq_gap",  {15'd0, irq},     16'h0000);
        check("t4_pending",  {12'd0, pending}, 16'h0001);
        tick();
        check("t4_irq_again", {15'd0, irq}, 16'h0001);
        check("t4_vector",    irq_vector,   16'h0100);
        ack();
        check("t4_pending_end", {12'd0, pending}, 16'h0000);

        // Asynchronous reset in the middle of a request
        set_mask(4'b1111);
        pulse(4'b1010);
        tick();
        check("t5_irq_high", {15'd0, irq},     16'h0001);
        check("t5_pending",  {12'd0, pending}, 16'h000a);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_irq",     {15'd0, irq},     16'h0000);
        check("t5_rst_pending", {12'd0, pending}, 16'h0000);
        check("t5_rst_enable",  {12'd0, enable},  16'h0000);
        check("t5_rst_vector",  irq_vector,       16'h0100);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("t5_irq_after", {15'd0, irq}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
